// File: rtl/icache_ctrl.sv
// Direct-mapped instruction-cache controller: tags/valids in flops, line data in an external SRAM.
// Misses refill a 32 B line as 8 word beats, write it in one SRAM cycle, re-read and respond.
module icache_ctrl #(
  parameter int INDEX_W = 6,
  parameter int ADDR_W  = 32,
  parameter int BEATS   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     req_addr_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_data_o,
  input  logic                  flush_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_W-1:0]     mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [31:0]           mem_rsp_data_i,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [3:0]            sram_wmask_o,
  output logic [12:0]           sram_addr_o,
  output logic [32*BEATS-1:0]   sram_wdata_o,
  input  logic [31:0]           sram_rdata_i
);

  localparam int LINES  = 1 << INDEX_W;
  localparam int TAG_W  = ADDR_W - INDEX_W - 5;
  localparam int LINE_W = 32 * BEATS;
  localparam int CNT_W  = $clog2(BEATS);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_MISS_REQ = 3'd2;
  localparam logic [2:0] S_REFILL   = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_REREAD   = 3'd5;

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tags [LINES];
  logic [ADDR_W-1:0]  addr_q;
  logic [LINE_W-1:0]  line;
  logic [CNT_W-1:0]   cnt;
  logic               flush_pend;

  logic [INDEX_W-1:0] idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic [2:0]         word_q;
  logic               hit;
  logic               flush_now;
  logic               accept;
  logic               beat;

  function automatic logic [12:0] sram_word_addr(input logic [INDEX_W-1:0] idx,
                                                 input logic [2:0] w);
    logic [12:0] a;
    a = '0;
    a[INDEX_W+2:0] = {idx, w};
    return a;
  endfunction

  assign idx_q     = addr_q[INDEX_W+4:5];
  assign tag_q     = addr_q[ADDR_W-1:INDEX_W+5];
  assign word_q    = addr_q[4:2];
  assign hit       = (state == S_LOOKUP) && valid[idx_q] && (tags[idx_q] == tag_q);
  // A flush deferred from a busy state is applied like a live one on the first IDLE cycle.
  assign flush_now = (state == S_IDLE) && (flush_i || flush_pend);
  assign accept    = req_valid_i && req_ready_o;
  assign beat      = (state == S_REFILL) && mem_rsp_valid_i;

  assign mem_req_addr_o = {addr_q[ADDR_W-1:5], 5'b0};
  assign sram_wdata_o   = line;

  always_comb begin
    state_nxt       = state;
    req_ready_o     = 1'b0;
    rsp_valid_o     = 1'b0;
    rsp_data_o      = '0;
    mem_req_valid_o = 1'b0;
    sram_csb_o      = 1'b1;
    sram_web_o      = 1'b1;
    sram_wmask_o    = 4'h0;
    sram_addr_o     = '0;
    case (state)
      S_IDLE: begin
        req_ready_o = !(flush_i || flush_pend);
        if (req_valid_i && req_ready_o) begin
          sram_csb_o  = 1'b0;
          sram_addr_o = sram_word_addr(req_addr_i[INDEX_W+4:5], req_addr_i[4:2]);
          state_nxt   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          rsp_valid_o = 1'b1;
          rsp_data_o  = sram_rdata_i;
          state_nxt   = S_IDLE;
        end else begin
          state_nxt   = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_nxt = S_REFILL;
      end
      S_REFILL: begin
        if (beat && cnt == CNT_W'(BEATS - 1)) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        sram_csb_o   = 1'b0;
        sram_web_o   = 1'b0;
        sram_wmask_o = 4'hF;
        sram_addr_o  = sram_word_addr(idx_q, 3'b000);
        state_nxt    = S_REREAD;
      end
      S_REREAD: begin
        sram_csb_o  = 1'b0;
        sram_addr_o = sram_word_addr(idx_q, word_q);
        state_nxt   = S_LOOKUP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      valid      <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE)
        flush_pend <= 1'b0;
      else if (flush_i)
        flush_pend <= 1'b1;
      if (flush_now)
        valid <= '0;
      else if (state == S_WRITE)
        valid[idx_q] <= 1'b1;
      if (state == S_MISS_REQ && mem_req_ready_i)
        cnt <= '0;
      else if (beat)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Datapath registers carry no reset; they are only consumed once the FSM qualifies them.
  always_ff @(posedge clk_i) begin
    if (accept)
      addr_q <= req_addr_i;
    if (beat)
      line[32*cnt +: 32] <= mem_rsp_data_i;
    if (state == S_WRITE)
      tags[idx_q] <= tag_q;
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: behavioural SRAM and memory, expected words queued per fetch.
`timescale 1ns/1ps
module tb_icache_ctrl;

  localparam int INDEX_W = 6;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic         flush = 1'b0;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid = 1'b0;
  logic [31:0]  mem_rsp_data = '0;
  logic         sram_csb;
  logic         sram_web;
  logic [3:0]   sram_wmask;
  logic [12:0]  sram_addr;
  logic [255:0] sram_wdata;
  logic [31:0]  sram_rdata = '0;

  icache_ctrl #(.INDEX_W(INDEX_W), .ADDR_W(ADDR_W), .BEATS(BEATS)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .flush_i(flush),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_req_addr_o(mem_req_addr),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
    .sram_csb_o(sram_csb), .sram_web_o(sram_web), .sram_wmask_o(sram_wmask),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] sram_mem [8192];
  int          wr_cnt = 0;
  logic [12:0] wr_addr = '0;
  logic [3:0]  wr_mask = '0;
  always @(posedge clk) begin
    if (!sram_csb && !sram_web) begin
      for (int k = 0; k < 8; k++) sram_mem[int'(sram_addr) + k] <= sram_wdata[32*k +: 32];
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= sram_addr;
      wr_mask <= sram_wmask;
    end else if (!sram_csb) begin
      sram_rdata <= sram_mem[sram_addr];
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  bit          f_got, f_missed, f_unstable;
  logic [31:0] f_data, f_maddr;
  int          f_lat, f_memreq_lat, f_after_beat, f_vld_cnt;

  // Drives one fetch and services any refill it causes; results land in the f_* variables.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] base,
                       input int rdy_delay, input int gap_max, input int flush_beat);
    int t, stall, nb, gap, phase, acc, lastb;
    f_got = 0; f_missed = 0; f_unstable = 0; f_data = '0; f_maddr = '0;
    f_lat = -1; f_memreq_lat = -1; f_after_beat = -1; f_vld_cnt = 0;
    stall = 0; nb = 0; gap = 0; phase = 0; lastb = -1;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    req_valid = 1'b1; req_addr = addr; acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    for (t = 0; t < 300 && !f_got; t++) begin
      if (rsp_valid) begin
        f_got = 1; f_data = rsp_data; f_lat = cyc - acc;
        if (lastb >= 0) f_after_beat = cyc - lastb;
      end else begin
        flush = 1'b0;
        mem_rsp_valid = 1'b0;
        if (phase == 0 && mem_req_valid) begin
          if (!f_missed) begin f_missed = 1; f_maddr = mem_req_addr; f_memreq_lat = cyc - acc; end
          else if (mem_req_addr !== f_maddr) f_unstable = 1;
          f_vld_cnt++;
          if (stall < rdy_delay) begin mem_req_ready = 1'b0; stall++; end
          else begin mem_req_ready = 1'b1; phase = 1; end
        end else if (phase == 1) begin
          mem_req_ready = 1'b0;
          if (gap > 0) gap--;
          else if (nb < BEATS) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = base + 32'(nb);
            if (nb == flush_beat) flush = 1'b1;
            lastb = cyc; nb++;
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 1)) : 0;
          end
        end
        @(negedge clk);
      end
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req_valid); end
    n_cmp++; if ({sram_csb, sram_web, sram_wmask, sram_addr} !== {1'b1, 1'b1, 4'h0, 13'h0})
      begin n_fail++; $display("FAIL reset_sram got=%b%b %h %h exp=11 0 0", sram_csb, sram_web, sram_wmask, sram_addr); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    int w0;
    w0 = wr_cnt;
    exp_q.push_back(32'hA0);
    fetch(32'h40, 32'hA0, 0, 0, -1);
    exp_w = exp_q.pop_front();
    n_cmp++; if (f_got !== 1'b1 || f_data !== exp_w) begin n_fail++; $display("FAIL cold_data got=%h exp=%h", f_data, exp_w); end
    n_cmp++; if (f_maddr !== 32'h40) begin n_fail++; $display("FAIL cold_mem_addr got=%h exp=40", f_maddr); end
    n_cmp++; if (f_memreq_lat !== 2) begin n_fail++; $display("FAIL cold_memreq_lat got=%0d exp=2", f_memreq_lat); end
    n_cmp++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL cold_write_count got=%0d exp=1", wr_cnt - w0); end
    n_cmp++; if (wr_mask !== 4'hF || wr_addr !== 13'h010) begin n_fail++; $display("FAIL cold_write got=%h/%h exp=f/010", wr_mask, wr_addr); end
    n_cmp++; if (f_after_beat !== 3) begin n_fail++; $display("FAIL cold_latency got=%0d exp=3", f_after_beat); end
  endtask

  task automatic test_hit();
    exp_q.push_back(32'hA1);
    fetch(32'h44, 32'h0, 0, 0, -1);
    exp_w = exp_q.pop_front();
    n_cmp++; if (f_data !== exp_w) begin n_fail++; $display("FAIL hit_data got=%h exp=%h", f_data, exp_w); end
    n_cmp++; if (f_lat !== 1) begin n_fail++; $display("FAIL hit_latency got=%0d exp=1", f_lat); end
    n_cmp++; if (f_missed !== 1'b0) begin n_fail++; $display("FAIL hit_memreq got=%b exp=0", f_missed); end
  endtask

  task automatic test_alias();
    exp_q.push_back(32'hB0);
    fetch(32'h40 + (32'd32 << INDEX_W), 32'hB0, 0, 0, -1);
    exp_w = exp_q.pop_front();
    n_cmp++; if (f_missed !== 1'b1 || f_maddr !== 32'h840) begin n_fail++; $display("FAIL alias_miss got=%b/%h exp=1/840", f_missed, f_maddr); end
    n_cmp++; if (f_data !== exp_w) begin n_fail++; $display("FAIL alias_data got=%h exp=%h", f_data, exp_w); end
    exp_q.push_back(32'hB1);
    fetch(32'h844, 32'h0, 0, 0, -1);
    exp_w = exp_q.pop_front();
    n_cmp++; if (f_missed !== 1'b0 || f_data !== exp_w) begin n_fail++; $display("FAIL alias_hit got=%b/%h exp=0/%h", f_missed, f_data, exp_w); end
    exp_q.push_back(32'hC0);
    fetch(32'h40, 32'hC0, 0, 0, -1);
    exp_w = exp_q.pop_front();
    n_cmp++; if (f_missed !== 1'b1 || f_data !== exp_w) begin n_fail++; $display("FAIL alias_evict got=%b/%h exp=1/%h", f_missed, f_data, exp_w); end
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h44;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_priority got=%b exp=0", req_ready); end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0 || sram_csb !== 1'b1) begin n_fail++; $display("FAIL flush_no_accept got=%b/%b exp=0/1", rsp_valid, sram_csb); end
    exp_q.push_back(32'hD1);
    fetch(32'h44, 32'hD0, 0, 0, -1);
    exp_w = exp_q.pop_front();
    n_cmp++; if (f_missed !== 1'b1 || f_data !== exp_w) begin n_fail++; $display("FAIL flush_idle_miss got=%b/%h exp=1/%h", f_missed, f_data, exp_w); end
  endtask

  task automatic test_flush_refill();
    exp_q.push_back(32'hE0);
    fetch(32'h60, 32'hE0, 0, 0, 2);
    exp_w = exp_q.pop_front();
    n_cmp++; if (f_got !== 1'b1 || f_data !== exp_w) begin n_fail++; $display("FAIL flush_refill_rsp got=%b/%h exp=1/%h", f_got, f_data, exp_w); end
    exp_q.push_back(32'hF1);
    fetch(32'h64, 32'hF0, 0, 0, -1);
    exp_w = exp_q.pop_front();
    n_cmp++; if (f_missed !== 1'b1 || f_data !== exp_w) begin n_fail++; $display("FAIL flush_refill_after got=%b/%h exp=1/%h", f_missed, f_data, exp_w); end
  endtask

  task automatic test_stall_gaps();
    exp_q.push_back(32'h1000_0002);
    fetch(32'h108, 32'h1000_0000, 5, 3, -1);
    exp_w = exp_q.pop_front();
    n_cmp++; if (f_vld_cnt !== 6 || f_unstable !== 1'b0) begin n_fail++; $display("FAIL stall_req got=%0d/%b exp=6/0", f_vld_cnt, f_unstable); end
    n_cmp++; if (f_maddr !== 32'h100 || f_data !== exp_w) begin n_fail++; $display("FAIL stall_data got=%h/%h exp=100/%h", f_maddr, f_data, exp_w); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < BEATS; k++) begin
      exp_q.push_back(32'h1000_0000 + 32'(k));
      fetch(32'h100 + 32'(4*k), 32'h0, 0, 0, -1);
      exp_w = exp_q.pop_front();
      n_cmp++; if (f_missed !== 1'b0 || f_data !== exp_w) begin n_fail++; $display("FAIL b2b_word%0d got=%b/%h exp=0/%h", k, f_missed, f_data, exp_w); end
    end
  endtask

  task automatic test_reset_mid_refill();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h80;
    @(negedge clk);
    req_valid = 1'b0;
    for (int t = 0; t < 20 && !mem_req_valid; t++) @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_memreq got=%b exp=1", mem_req_valid); end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h200 + 32'(b);
      @(negedge clk);
    end
    rst_n = 1'b0; mem_rsp_data = 32'h204;
    #1;
    n_cmp++; if ({req_ready, rsp_valid, mem_req_valid, sram_csb, sram_web} !== 5'b10011 || sram_wmask !== 4'h0 || sram_addr !== 13'h0)
      begin n_fail++; $display("FAIL midrst_outputs got=%b %h %h exp=10011 0 0", {req_ready, rsp_valid, mem_req_valid, sram_csb, sram_web}, sram_wmask, sram_addr); end
    @(negedge clk);
    rst_n = 1'b1; mem_rsp_data = 32'h205;
    @(negedge clk); mem_rsp_data = 32'h206;
    @(negedge clk); mem_rsp_data = 32'h207;
    @(negedge clk); mem_rsp_valid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ignore got=%b/%b exp=0/0", rsp_valid, mem_req_valid); end
    exp_q.push_back(32'h300);
    fetch(32'h80, 32'h300, 0, 1, -1);
    exp_w = exp_q.pop_front();
    n_cmp++; if (f_missed !== 1'b1 || f_maddr !== 32'h80 || f_data !== exp_w) begin n_fail++; $display("FAIL midrst_refill got=%b/%h/%h exp=1/80/%h", f_missed, f_maddr, f_data, exp_w); end
    exp_q.push_back(32'h307);
    fetch(32'h9C, 32'h0, 0, 0, -1);
    exp_w = exp_q.pop_front();
    n_cmp++; if (f_missed !== 1'b0 || f_data !== exp_w) begin n_fail++; $display("FAIL midrst_line got=%b/%h exp=0/%h", f_missed, f_data, exp_w); end
    exp_q.push_back(32'h400);
    fetch(32'h40, 32'h400, 0, 0, -1);
    exp_w = exp_q.pop_front();
    n_cmp++; if (f_missed !== 1'b1 || f_data !== exp_w) begin n_fail++; $display("FAIL midrst_valids got=%b/%h exp=1/%h", f_missed, f_data, exp_w); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_alias();
    test_flush_idle();
    test_flush_refill();
    test_stall_gaps();
    test_back_to_back();
    test_reset_mid_refill();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
